// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, then a sign-fix
// cycle, then the result is held until the execute stage takes it.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_result_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       count_q;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     opb_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                neg_q;
  logic                rem_neg_q;
  logic [XLEN-1:0]     result_q;
  logic                valid_q;
  logic                busy_q;
  logic                ready_q;

  function automatic logic [XLEN-1:0] negate_x(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*XLEN-1:0] negate_2x(input logic [2*XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0, ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    a_signed = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
    b_signed = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
    a_neg    = a_signed && i_a[XLEN-1];
    b_neg    = b_signed && i_b[XLEN-1];
    a_mag    = a_neg ? negate_x(i_a) : i_a;
    b_mag    = b_neg ? negate_x(i_b) : i_b;
    div0     = i_op[2] && (i_b == '0);
    ovf      = i_op[2] && !i_op[0] && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (&i_b);
    fast_res = '0;
    if (div0)
      fast_res = i_op[1] ? i_a : '1;
    else if (ovf)
      fast_res = i_op[1] ? '0 : i_a;
  end

  // Shared accumulator: multiply keeps {partial product, multiplier}; divide keeps
  // {partial remainder, dividend/quotient} and shifts the quotient bit in at the bottom.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              q_bit;
  logic [2*XLEN-1:0] step_acc;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    q_bit     = !div_diff[XLEN];
    if (op_q[2])
      step_acc = {(q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
    else
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? negate_2x(acc_q) : acc_q;
    quo_fix  = neg_q ? negate_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = rem_neg_q ? negate_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])
      fix_res = op_q[1] ? rem_fix : quo_fix;
    else
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            op_q    <= i_op;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (div0 || ovf) begin
              state_q  <= DONE;
              result_q <= fast_res;
              valid_q  <= 1'b1;
            end else begin
              state_q   <= CALC;
              count_q   <= CW'(XLEN - 1);
              acc_q     <= {{XLEN{1'b0}}, a_mag};
              opb_q     <= b_mag;
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
            end
          end
        end
        CALC: begin
          acc_q   <= step_acc;
          count_q <= count_q - 1'b1;
          if (count_q == '0)
            state_q <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (i_result_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, fast paths,
// back-pressure, reset and flush aborts.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_result_ready;
  logic [2:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_op           (i_op),
    .i_a            (i_a),
    .i_b            (i_b),
    .o_valid        (o_valid),
    .i_result_ready (i_result_ready),
    .o_result       (o_result),
    .o_busy         (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request at a falling edge and returns #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Counts falling edges after the accept edge until o_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 100);
  endtask

  task automatic retire();
    @(negedge clk);
    i_result_ready = 1'b1;
    @(posedge clk);
    #1;
    i_result_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    check({tag, " latency"}, lat, exp_lat);
    check(tag, o_result, exp);
    retire();
    check({tag, " ready after retire"}, {31'b0, o_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_result_ready = 1'b0;
    i_op = 3'b0; i_a = '0; i_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", {31'b0, o_valid}, 32'd0);
    check("reset busy", {31'b0, o_busy}, 32'd0);
    check("reset ready", {31'b0, o_ready}, 32'd1);
    check("reset result", o_result, 32'd0);
    i_reset = 1'b0;

    // Multiply family
    run("mul ff*ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
    run("mulhu ff*ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulh ff*ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run("mulhsu ff*ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("mul 12345*678", 3'b000, 32'd12345, 32'd678, 32'h007F_B6F6, 34);

    // Divide family
    run("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("div 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run("rem 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 34);
    run("divu fff9/2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
    run("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 34);

    // Fast paths
    run("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu 5/0", 3'b111, 32'd5, 32'd0, 32'h0000_0005, 1);
    run("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Reset in the middle of a divide
    issue(3'b100, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    check("midreset valid", {31'b0, o_valid}, 32'd0);
    check("midreset busy", {31'b0, o_busy}, 32'd0);
    check("midreset ready", {31'b0, o_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) seen = 1;
    end
    check("midreset no valid", seen, 0);

    // Back-pressure with a queued request
    issue(3'b101, 32'd100, 32'd7);
    wait_valid(lat);
    check("bp latency", lat, 34);
    for (int i = 0; i < 5; i++) begin
      check("bp result held", o_result, 32'd14);
      check("bp ready low", {31'b0, o_ready}, 32'd0);
      check("bp valid held", {31'b0, o_valid}, 32'd1);
      @(negedge clk);
    end
    i_result_ready = 1'b1;
    i_valid = 1'b1; i_op = 3'b000; i_a = 32'd12345; i_b = 32'd678;
    @(posedge clk);
    #1;
    i_result_ready = 1'b0;
    check("bp retire valid", {31'b0, o_valid}, 32'd0);
    check("bp retire ready", {31'b0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("bp queued accepted", {31'b0, o_busy}, 32'd1);
    wait_valid(lat);
    check("bp queued latency", lat, 34);
    check("bp queued result", o_result, 32'h007F_B6F6);
    retire();

    // Flush during a multiply, then a new request right after
    issue(3'b000, 32'd3, 32'd5);
    repeat (19) @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check("flush valid", {31'b0, o_valid}, 32'd0);
    check("flush busy", {31'b0, o_busy}, 32'd0);
    check("flush ready", {31'b0, o_ready}, 32'd1);
    issue(3'b100, 32'd7, 32'hFFFF_FFFE);
    wait_valid(lat);
    check("post-flush latency", lat, 34);
    check("post-flush result", o_result, 32'hFFFF_FFFD);
    retire();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits in the execute stage beside the ALU. It accepts an operation from the pipeline, iterates one radix-2 step per cycle, applies sign correction, and holds the result until execute consumes it.
- Execute stalls on `o_busy`. A pipeline flush aborts the operation in flight.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  abort the current operation; sampled every cycle
- i_valid  in  1  operation request
- o_ready  out  1  request can be accepted this cycle
- i_op  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- i_a, i_b  in  XLEN  rs1, rs2 operands
- o_valid  out  1  result available
- i_result_ready  in  1  consumer takes the result this cycle
- o_result  out  XLEN  result
- o_busy  out  1  high in every state except IDLE

Behaviour:
- The clock and reset are one clock domain; reset is synchronous and active-high, as already decided.
- Reset / flush: state=IDLE, count=0, o_valid=0, o_result=0, o_busy=0, o_ready=1. Accumulators clear. Flush has the same effect as reset, and reset takes priority over flush.
- Handshake:
  - Accept on the edge where i_valid && o_ready; operands and op are latched then.
  - o_ready=1 only in IDLE.
  - A result is retired on the edge where o_valid && i_result_ready.
  - While o_valid=1 and i_result_ready=0, o_result is held stable.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on accept, with count=XLEN-1. Operands are converted to magnitudes per signedness:
  - mulh: both signed.
  - mulhsu: a signed, b unsigned.
  - div/rem: both signed.
  - mul/mulhu/divu/remu: unsigned.
- IDLE -> DONE directly on accept (fast path) for the special cases below; o_valid rises 1 cycle after the accept edge.
  - Divide by zero (b==0): div/divu quotient = all ones (0xFFFFFFFF); rem/remu = i_a.
  - Signed overflow (div/rem with a=0x80000000, b=0xFFFFFFFF): div = 0x80000000; rem = 0.
- CALC, multiply: one shift-add step per cycle into a 2*XLEN product register.
- CALC, divide: one restoring shift-subtract step per cycle, using a single XLEN+1-bit subtractor. The quotient bit is 1 when the difference is non-negative.
- CALC: count decrements each cycle; CALC -> FIX when count==0 (exactly XLEN cycles in CALC).
- FIX: one cycle.
  - Negate the product if the operand signs differ (signed forms).
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the result: low half for mul, high half for mulh/mulhsu/mulhu, quotient for div/divu, remainder for rem/remu.
  - FIX -> DONE.
- DONE: o_valid=1. DONE -> IDLE on i_result_ready. A new request is not accepted in the same cycle as retirement (o_ready=0 in DONE).
- Latency: normal operations raise o_valid XLEN+2 cycles after the accept edge (34 for XLEN=32). Throughput is one operation per XLEN+3 cycles minimum.
- Width rules:
  - All arithmetic is modulo 2^XLEN, except the 2*XLEN product.
  - Negation is two's complement.
  - mulhsu with a negative a: the full product is negated as a 2*XLEN value before the high half is taken.
- Flush in any state returns to IDLE on that edge. No o_valid is produced for the aborted operation, and a flush in DONE discards the pending result.
- i_valid while busy is ignored; the requester holds its request until o_ready.
- Op and operand inputs are don't-care when not accepting.

Test Plan:
- Reset mid-CALC (assert i_reset at cycle 10 after accepting div 100/7) -> next cycle state IDLE, o_valid=0, o_busy=0, o_ready=1.
- mul 0xFFFFFFFF × 0xFFFFFFFF -> o_result=0x00000001 after exactly 34 cycles; mulhu with the same operands -> 0xFFFFFFFE; mulh with the same operands -> 0x00000000.
- Signed divide and remainder:
  - div -7/2 -> 0xFFFFFFFD (-3); rem -7/2 -> 0xFFFFFFFF (-1).
  - divu 0xFFFFFFF9/2 -> 0x7FFFFFFC.
  - mulhsu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Special cases with the fast path (o_valid 1 cycle after accept):
  - div 5/0 -> 0xFFFFFFFF; remu 5/0 -> 0x00000005.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000; rem with the same operands -> 0.
- Back-pressure: hold i_result_ready=0 for 5 cycles after o_valid -> o_result stable and o_ready=0 throughout; then i_result_ready=1 -> IDLE next cycle, with a queued i_valid accepted the cycle after.
- Flush at cycle 20 of a mul, with a new request presented the next cycle -> first operation never produces o_valid; new operation accepted and its correct result appears 34 cycles after its accept edge.
